// File: rtl/ext_interrupt_arbiter.sv
// External-interrupt arbiter: per-source pending/in-service tracking, priority/threshold
// arbitration and claim/complete handshake. Optional: EXT_INTERRUPT_EDGE_DETECT_EN (edge capture + re-pend).
module ext_interrupt_arbiter #(
  parameter  int NUM_SOURCES    = 8,
  parameter  int PRIORITY_WIDTH = 3,
  localparam int CODE_WIDTH     = $clog2(NUM_SOURCES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SOURCES-1:0] srcReq,
  input  logic                  cfgWE,
  input  logic [CODE_WIDTH:0]   cfgAddr,
  input  logic [31:0]           cfgWData,
  output logic [31:0]           cfgRData,
  input  logic                  claim,
  input  logic                  complete,
  input  logic [CODE_WIDTH-1:0] completeCode,
  output logic                  reqExternalInterrupt,
  output logic [CODE_WIDTH-1:0] externalInterruptCode
);

  localparam logic [CODE_WIDTH:0] ADDR_ENABLE    = '0;
  localparam logic [CODE_WIDTH:0] ADDR_THRESHOLD = (CODE_WIDTH + 1)'(NUM_SOURCES + 1);
  localparam int                  WDATA_USED     = (NUM_SOURCES > PRIORITY_WIDTH) ? NUM_SOURCES : PRIORITY_WIDTH;

  logic [NUM_SOURCES-1:0]    enable_r;
  logic [PRIORITY_WIDTH-1:0] prio_r [NUM_SOURCES];
  logic [PRIORITY_WIDTH-1:0] threshold_r;
  logic [NUM_SOURCES-1:0]    pending_r;
  logic [NUM_SOURCES-1:0]    inService_r;
  logic [NUM_SOURCES-1:0]    pendingNext_s;
  logic [NUM_SOURCES-1:0]    inServiceNext_s;
  logic [NUM_SOURCES-1:0]    reqEvent_s;
  logic [NUM_SOURCES-1:0]    claimHit_s;
  logic [NUM_SOURCES-1:0]    completeHit_s;
  logic [NUM_SOURCES-1:0]    eligible_s;
  logic                      winValid_s;
  logic [CODE_WIDTH-1:0]     winCode_s;
  logic [PRIORITY_WIDTH-1:0] winPrio_s;
  logic                      unusedWData_s;

  assign unusedWData_s = ^cfgWData[31:WDATA_USED];

`ifdef EXT_INTERRUPT_EDGE_DETECT_EN
  logic [NUM_SOURCES-1:0] srcReqPrev_r;
  logic [NUM_SOURCES-1:0] rePend_r;
  logic [NUM_SOURCES-1:0] rePendNext_s;

  // Request history and re-pend flags for edge capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      srcReqPrev_r <= '0;
      rePend_r     <= '0;
    end else begin
      srcReqPrev_r <= srcReq;
      rePend_r     <= rePendNext_s;
    end
  end

  assign reqEvent_s = srcReq & ~srcReqPrev_r;
`else
  assign reqEvent_s = srcReq;
`endif

  // Decode claim/complete into per-source hits; only valid state transitions register
  always_comb begin
    claimHit_s    = '0;
    completeHit_s = '0;
    eligible_s    = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      claimHit_s[i]    = claim && pending_r[i] && (externalInterruptCode == CODE_WIDTH'(i + 1));
      completeHit_s[i] = complete && inService_r[i] && (completeCode == CODE_WIDTH'(i + 1));
      eligible_s[i]    = pending_r[i] && !claimHit_s[i] && enable_r[i] && (prio_r[i] > threshold_r);
    end
  end

  // Per-source IDLE -> PENDING -> IN_SERVICE lifecycle
  always_comb begin
    pendingNext_s   = pending_r;
    inServiceNext_s = inService_r;
`ifdef EXT_INTERRUPT_EDGE_DETECT_EN
    rePendNext_s    = rePend_r;
`endif
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (claimHit_s[i]) begin
        pendingNext_s[i]   = 1'b0;
        inServiceNext_s[i] = 1'b1;
      end else if (completeHit_s[i]) begin
        inServiceNext_s[i] = 1'b0;
`ifdef EXT_INTERRUPT_EDGE_DETECT_EN
        pendingNext_s[i]   = rePend_r[i] | reqEvent_s[i];
        rePendNext_s[i]    = 1'b0;
`else
        pendingNext_s[i]   = 1'b0;
`endif
      end else if (inService_r[i]) begin
`ifdef EXT_INTERRUPT_EDGE_DETECT_EN
        rePendNext_s[i]    = rePend_r[i] | reqEvent_s[i];
`else
        inServiceNext_s[i] = inService_r[i];
`endif
      end else begin
        pendingNext_s[i]   = pending_r[i] | reqEvent_s[i];
      end
    end
  end

  // Ascending scan with strict compare keeps the lowest code on a priority tie
  always_comb begin : arbScan
    logic take;
    winValid_s = 1'b0;
    winCode_s  = '0;
    winPrio_s  = '0;
    take       = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      take       = eligible_s[i] && (prio_r[i] > winPrio_s);
      winValid_s = take ? 1'b1 : winValid_s;
      winPrio_s  = take ? prio_r[i] : winPrio_s;
      winCode_s  = take ? CODE_WIDTH'(i + 1) : winCode_s;
    end
  end

  // Source state and registered arbitration result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r             <= '0;
      inService_r           <= '0;
      reqExternalInterrupt  <= 1'b0;
      externalInterruptCode <= '0;
    end else begin
      pending_r             <= pendingNext_s;
      inService_r           <= inServiceNext_s;
      reqExternalInterrupt  <= winValid_s;
      externalInterruptCode <= winCode_s;
    end
  end

  // Configuration registers; unmapped addresses are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_r    <= '0;
      threshold_r <= '0;
      for (int k = 0; k < NUM_SOURCES; k++) begin
        prio_r[k] <= '0;
      end
    end else if (cfgWE) begin
      if (cfgAddr == ADDR_ENABLE) begin
        enable_r <= cfgWData[NUM_SOURCES-1:0];
      end
      if (cfgAddr == ADDR_THRESHOLD) begin
        threshold_r <= cfgWData[PRIORITY_WIDTH-1:0];
      end
      for (int k = 0; k < NUM_SOURCES; k++) begin
        if (cfgAddr == (CODE_WIDTH + 1)'(k + 1)) begin
          prio_r[k] <= cfgWData[PRIORITY_WIDTH-1:0];
        end
      end
    end
  end

  // Combinational config readback, zero-extended
  always_comb begin
    cfgRData = 32'd0;
    if (cfgAddr == ADDR_ENABLE) begin
      cfgRData[NUM_SOURCES-1:0] = enable_r;
    end else if (cfgAddr == ADDR_THRESHOLD) begin
      cfgRData[PRIORITY_WIDTH-1:0] = threshold_r;
    end else begin
      for (int k = 0; k < NUM_SOURCES; k++) begin
        cfgRData = (cfgAddr == (CODE_WIDTH + 1)'(k + 1)) ? 32'(prio_r[k]) : cfgRData;
      end
    end
  end

endmodule

// File: tb/tb_ext_interrupt_arbiter.sv
// Directed + randomized bench for ext_interrupt_arbiter against a source-lifecycle reference model.
module tb_ext_interrupt_arbiter;
  localparam int NS   = 8;
  localparam int CW   = 4;
  localparam int IDLE = 0;
  localparam int PEND = 1;
  localparam int SERV = 2;
`ifdef EXT_INTERRUPT_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] srcReq;
  logic          cfgWE;
  logic [CW:0]   cfgAddr;
  logic [31:0]   cfgWData;
  logic [31:0]   cfgRData;
  logic          claim;
  logic          complete;
  logic [CW-1:0] completeCode;
  logic          reqExternalInterrupt;
  logic [CW-1:0] externalInterruptCode;

  always #5 clk = ~clk;

  ext_interrupt_arbiter dut (
    .clk(clk), .rst(rst), .srcReq(srcReq), .cfgWE(cfgWE), .cfgAddr(cfgAddr),
    .cfgWData(cfgWData), .cfgRData(cfgRData), .claim(claim), .complete(complete),
    .completeCode(completeCode), .reqExternalInterrupt(reqExternalInterrupt),
    .externalInterruptCode(externalInterruptCode)
  );

  int nCompared = 0;
  int nMismatched = 0;

  int         mSt   [NS];
  bit         mRe   [NS];
  bit         mPrev [NS];
  int         mPri  [NS];
  logic [7:0] mEn;
  int         mThr;
  int         mReq;
  int         mCode;

  task automatic modelReset();
    for (int i = 0; i < NS; i++) begin
      mSt[i] = IDLE; mRe[i] = 1'b0; mPrev[i] = 1'b0; mPri[i] = 0;
    end
    mEn = 8'h00; mThr = 0; mReq = 0; mCode = 0;
  endtask

  function automatic int modelRead(input int a);
    if (a == 0) return int'(mEn);
    else if (a >= 1 && a <= NS) return mPri[a-1];
    else if (a == NS + 1) return mThr;
    else return 0;
  endfunction

  // One clock edge of the reference: arbitrate on the pre-edge state, then advance sources.
  task automatic modelEdge();
    int  oldSt [NS];
    int  claimC;
    int  best;
    bit  ev;
    if (rst) begin
      modelReset();
      return;
    end
    oldSt  = mSt;
    claimC = claim ? mCode : 0;
    best   = 0;
    for (int p = 7; p >= 1; p--)
      for (int i = 0; i < NS; i++)
        if (best == 0 && p > mThr && oldSt[i] == PEND && mEn[i] && mPri[i] == p && claimC != i + 1)
          best = i + 1;
    mReq  = (best != 0) ? 1 : 0;
    mCode = best;
    for (int i = 0; i < NS; i++) begin
      ev = EDGE ? (srcReq[i] && !mPrev[i]) : srcReq[i];
      if (claimC == i + 1 && oldSt[i] == PEND) begin
        mSt[i] = SERV;
      end else if (complete && int'(completeCode) == i + 1 && oldSt[i] == SERV) begin
        mSt[i] = (EDGE && (mRe[i] || ev)) ? PEND : IDLE;
        mRe[i] = 1'b0;
      end else if (oldSt[i] == SERV) begin
        if (EDGE && ev) mRe[i] = 1'b1;
      end else if (oldSt[i] == IDLE && ev) begin
        mSt[i] = PEND;
      end
      mPrev[i] = srcReq[i];
    end
    if (cfgWE) begin
      if (cfgAddr == 0) mEn = cfgWData[7:0];
      else if (cfgAddr <= NS) mPri[cfgAddr-1] = int'(cfgWData[2:0]);
      else if (cfgAddr == NS + 1) mThr = int'(cfgWData[2:0]);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    check({tag, " req"}, 32'(reqExternalInterrupt), mReq);
    check({tag, " code"}, 32'(externalInterruptCode), mCode);
    check({tag, " rdata"}, cfgRData, modelRead(int'(cfgAddr)));
    claim = 1'b0; complete = 1'b0; cfgWE = 1'b0;
  endtask

  task automatic cfgWrite(input int a, input int d, input string tag);
    cfgWE = 1'b1; cfgAddr = a[CW:0]; cfgWData = d;
    step(tag);
  endtask

  task automatic doComplete(input int c, input string tag);
    complete = 1'b1; completeCode = c[CW-1:0];
    step(tag);
  endtask

  initial begin
    rst = 1'b1; srcReq = '0; cfgWE = 1'b0; cfgAddr = '0; cfgWData = '0;
    claim = 1'b0; complete = 1'b0; completeCode = '0;
    modelReset();
    step("reset0");
    step("reset1");
    rst = 1'b0;

    // 1: reset while src3 pending / asserted
    cfgWrite(0, 32'hFF, "t1 en");
    cfgWrite(3, 4, "t1 pri3");
    srcReq = 8'h04;
    step("t1 cap");
    step("t1 arb");
    check("t1 pre req", 32'(reqExternalInterrupt), 32'd1);
    check("t1 pre code", 32'(externalInterruptCode), 32'd3);
    cfgAddr = '0;
    #2; rst = 1'b1; #1;
    check("t1 rst req", 32'(reqExternalInterrupt), 32'd0);
    check("t1 rst code", 32'(externalInterruptCode), 32'd0);
    check("t1 rst rdata", cfgRData, 32'd0);
    modelReset();
    srcReq = '0;
    step("t1 hold");
    rst = 1'b0;

    // 2: tie between codes 2 and 5 at priority 5
    cfgWrite(0, 32'hFF, "t2 en");
    cfgWrite(2, 5, "t2 pri2");
    cfgWrite(5, 5, "t2 pri5");
    cfgWrite(9, 2, "t2 thr");
    srcReq = 8'h12;
    step("t2 t1");
    check("t2 lat req", 32'(reqExternalInterrupt), 32'd0);
    srcReq = 8'h00;
    step("t2 t2");
    check("t2 req", 32'(reqExternalInterrupt), 32'd1);
    check("t2 code", 32'(externalInterruptCode), 32'd2);

    // 4: claim/complete sequencing
    claim = 1'b1; step("t4 claim2");
    check("t4 code5", 32'(externalInterruptCode), 32'd5);
    claim = 1'b1; step("t4 claim5");
    check("t4 req0", 32'(reqExternalInterrupt), 32'd0);
    doComplete(5, "t4 cpl5");
    doComplete(6, "t4 cpl6");
    check("t4 cpl6 req", 32'(reqExternalInterrupt), 32'd0);
    srcReq = 8'h10; step("t4 re5");
    srcReq = 8'h00; step("t4 re5 arb");
    check("t4 idle5 code", 32'(externalInterruptCode), 32'd5);
    claim = 1'b1; step("t4 claim5b");
    doComplete(5, "t4 cpl5b");
    doComplete(2, "t4 cpl2");

    // 3: strict threshold compare
    cfgWrite(7, 2, "t3 pri7");
    srcReq = 8'h40; step("t3 cap");
    srcReq = 8'h00; step("t3 a");
    step("t3 b");
    check("t3 masked req", 32'(reqExternalInterrupt), 32'd0);
    cfgWrite(9, 1, "t3 thr1");
    step("t3 c");
    check("t3 req", 32'(reqExternalInterrupt), 32'd1);
    check("t3 code", 32'(externalInterruptCode), 32'd7);
    claim = 1'b1; step("t3 claim");
    doComplete(7, "t3 cpl");

    // 5: level held through claim/complete
    cfgWrite(1, 6, "t5 pri1");
    srcReq = 8'h01; step("t5 cap");
    step("t5 arb");
    check("t5 code1", 32'(externalInterruptCode), 32'd1);
    claim = 1'b1; step("t5 claim");
    check("t5 claimed req", 32'(reqExternalInterrupt), 32'd0);
    doComplete(1, "t5 cpl");
    check("t5 cpl req", 32'(reqExternalInterrupt), 32'd0);
    step("t5 a");
    step("t5 b");
    check("t5 rearm req", 32'(reqExternalInterrupt), EDGE ? 32'd0 : 32'd1);
    check("t5 rearm code", 32'(externalInterruptCode), EDGE ? 32'd0 : 32'd1);
    srcReq = 8'h00;
    claim = 1'b1; step("t5 claim2");
    doComplete(1, "t5 cpl2");

    // 6: pulse during in-service
    srcReq = 8'h01; step("t6 cap");
    srcReq = 8'h00; step("t6 arb");
    check("t6 code1", 32'(externalInterruptCode), 32'd1);
    claim = 1'b1; step("t6 claim");
    srcReq = 8'h01; step("t6 pulse");
    srcReq = 8'h00; step("t6 pulse end");
    doComplete(1, "t6 cpl");
    step("t6 after");
    check("t6 repend req", 32'(reqExternalInterrupt), EDGE ? 32'd1 : 32'd0);
    check("t6 repend code", 32'(externalInterruptCode), EDGE ? 32'd1 : 32'd0);
    claim = 1'b1; step("t6 claim2");
    doComplete(1, "t6 cpl2");

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) srcReq = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cfgWE        = ($urandom_range(0, 7) == 0);
      cfgAddr      = 5'($urandom_range(0, 12));
      cfgWData     = $urandom;
      claim        = ($urandom_range(0, 3) == 0);
      complete     = ($urandom_range(0, 2) == 0);
      completeCode = 4'($urandom_range(0, 10));
      rst          = (n == 200);
      step("rnd");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
